// File: rtl/ysyx_24100006_csr_pkg.sv
// Shared CSR addresses, write-op encodings and field indices for the M-mode CSR unit.
package ysyx_24100006_csr_pkg;
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam logic [1:0] WOP_WRITE = 2'b00;
    localparam logic [1:0] WOP_SET   = 2'b01;
    localparam logic [1:0] WOP_CLR   = 2'b10;
    localparam logic [1:0] WOP_NOP   = 2'b11;

    localparam int MST_MIE    = 3;
    localparam int MST_MPIE   = 7;
    localparam int MST_MPP_LO = 11;
    localparam int MST_MPP_HI = 12;
    localparam int IRQ_EXT    = 11;

    localparam int CAUSE_MEI     = 11;
    localparam int CAUSE_ECALL_M = 11;
endpackage

// File: rtl/ysyx_24100006_csr_cnt64.sv
// Two-half 64-bit counter; a write to either half replaces it and skips that cycle's increment.
module ysyx_24100006_csr_cnt64 #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           inc,
    input  logic           wr_lo,
    input  logic           wr_hi,
    input  logic [W-1:0]   wdata,
    output logic [2*W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     count <= '0;
        else if (wr_lo) count[W-1:0] <= wdata;
        else if (wr_hi) count[2*W-1:W] <= wdata;
        else if (inc)   count <= count + 1'b1;
    end
endmodule

// File: rtl/ysyx_24100006_csr_unit.sv
// Machine-mode CSR file: mstatus stacking, external-irq gating, counters and trap/mret redirect.
module ysyx_24100006_csr_unit
    import ysyx_24100006_csr_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              CAUSE_W   = 5,
    parameter logic [XLEN-1:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [XLEN-1:0] MVENDORID = 32'h7973_7978,
    parameter logic [XLEN-1:0] MARCHID   = 32'd24100006,
    parameter int              HAS_CNT   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [11:0]        raddr,
    output logic [XLEN-1:0]    rdata,
    input  logic               wen,
    input  logic [1:0]         wop,
    input  logic [11:0]        waddr,
    input  logic [XLEN-1:0]    wdata,
    input  logic               trap_valid,
    input  logic               trap_intr,
    input  logic [CAUSE_W-1:0] trap_cause,
    input  logic [XLEN-1:0]    trap_pc,
    input  logic               mret_valid,
    input  logic               retire,
    input  logic               ext_irq,
    output logic               irq_take,
    output logic [XLEN-1:0]    redirect_pc,
    output logic [XLEN-1:0]    mtvec,
    output logic [XLEN-1:0]    mepc
);
    logic                mst_mie, mst_mpie, meie, mcause_int;
    logic [CAUSE_W-1:0]  mcause_code;
    logic [XLEN-1:0]     mtvec_q, mepc_q, mscratch_q;
    logic [XLEN-1:0]     mstatus_v, mcause_v, mie_v, mip_v, wold, wval, base;
    logic [2*XLEN-1:0]   mcycle, minstret;
    logic                csr_we;

    always_comb begin
        mstatus_v = '0;
        mstatus_v[MST_MPP_HI:MST_MPP_LO] = 2'b11;
        mstatus_v[MST_MIE]  = mst_mie;
        mstatus_v[MST_MPIE] = mst_mpie;
        mcause_v = '0;
        mcause_v[XLEN-1]    = mcause_int;
        mcause_v[CAUSE_W-1:0] = mcause_code;
        mie_v = '0;
        mie_v[IRQ_EXT] = meie;
        mip_v = '0;
        mip_v[IRQ_EXT] = ext_irq;
    end

    function automatic logic [XLEN-1:0] csr_rd(input logic [11:0] a);
        case (a)
            CSR_MSTATUS:   return mstatus_v;
            CSR_MIE:       return mie_v;
            CSR_MTVEC:     return mtvec_q;
            CSR_MSCRATCH:  return mscratch_q;
            CSR_MEPC:      return mepc_q;
            CSR_MCAUSE:    return mcause_v;
            CSR_MIP:       return mip_v;
            CSR_MCYCLE:    return mcycle[XLEN-1:0];
            CSR_MCYCLEH:   return mcycle[2*XLEN-1:XLEN];
            CSR_MINSTRET:  return minstret[XLEN-1:0];
            CSR_MINSTRETH: return minstret[2*XLEN-1:XLEN];
            CSR_MVENDORID: return MVENDORID;
            CSR_MARCHID:   return MARCHID;
            default:       return '0;
        endcase
    endfunction

    assign rdata = csr_rd(raddr);
    assign wold  = csr_rd(waddr);

    always_comb begin
        case (wop)
            WOP_WRITE: wval = wdata;
            WOP_SET:   wval = wold | wdata;
            WOP_CLR:   wval = wold & ~wdata;
            default:   wval = wold;
        endcase
    end

    // Traps and mret pre-empt any CSR write committed in the same cycle.
    assign csr_we = wen && (wop != WOP_NOP) && !trap_valid && !mret_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_mie     <= 1'b0;
            mst_mpie    <= 1'b0;
            meie        <= 1'b0;
            mtvec_q     <= MTVEC_RST & ~XLEN'(2);
            mepc_q      <= '0;
            mscratch_q  <= '0;
            mcause_int  <= 1'b0;
            mcause_code <= '0;
        end else if (trap_valid) begin
            mepc_q      <= trap_pc & ~XLEN'(3);
            mcause_int  <= trap_intr;
            mcause_code <= trap_cause;
            mst_mpie    <= mst_mie;
            mst_mie     <= 1'b0;
        end else if (mret_valid) begin
            mst_mie  <= mst_mpie;
            mst_mpie <= 1'b1;
        end else if (csr_we) begin
            case (waddr)
                CSR_MSTATUS: begin
                    mst_mie  <= wval[MST_MIE];
                    mst_mpie <= wval[MST_MPIE];
                end
                CSR_MIE:      meie       <= wval[IRQ_EXT];
                CSR_MTVEC:    mtvec_q    <= wval & ~XLEN'(2);
                CSR_MSCRATCH: mscratch_q <= wval;
                CSR_MEPC:     mepc_q     <= wval & ~XLEN'(3);
                CSR_MCAUSE: begin
                    mcause_int  <= wval[XLEN-1];
                    mcause_code <= wval[CAUSE_W-1:0];
                end
                default: ;
            endcase
        end
    end

    generate
        if (HAS_CNT != 0) begin : g_cnt
            ysyx_24100006_csr_cnt64 #(.W(XLEN)) u_mcycle (
                .clk(clk), .rst_n(rst_n), .inc(1'b1),
                .wr_lo(csr_we && waddr == CSR_MCYCLE),
                .wr_hi(csr_we && waddr == CSR_MCYCLEH),
                .wdata(wval), .count(mcycle)
            );
            ysyx_24100006_csr_cnt64 #(.W(XLEN)) u_minstret (
                .clk(clk), .rst_n(rst_n), .inc(retire),
                .wr_lo(csr_we && waddr == CSR_MINSTRET),
                .wr_hi(csr_we && waddr == CSR_MINSTRETH),
                .wdata(wval), .count(minstret)
            );
        end else begin : g_nocnt
            assign mcycle   = '0;
            assign minstret = '0;
        end
    endgenerate

    assign base = {mtvec_q[XLEN-1:2], 2'b00};

    always_comb begin
        if (mret_valid && !trap_valid)   redirect_pc = mepc_q;
        else if (mtvec_q[0] && trap_intr) redirect_pc = base + (XLEN'(trap_cause) << 2);
        else                              redirect_pc = base;
    end

    assign irq_take = mst_mie & meie & ext_irq;
    assign mtvec    = mtvec_q;
    assign mepc     = mepc_q;
endmodule

// File: tb/tb_ysyx_24100006_csr_unit.sv
// Self-checking bench for the CSR unit: reset table, trap/mret flow, priority and counters.
module tb_ysyx_24100006_csr_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] raddr, waddr;
    logic [31:0] rdata, wdata, trap_pc, redirect_pc, mtvec, mepc;
    logic        wen, trap_valid, trap_intr, mret_valid, retire, ext_irq, irq_take;
    logic [1:0]  wop;
    logic [4:0]  trap_cause;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    typedef struct {
        string       nm;
        logic [11:0] addr;
        logic [31:0] exp;
    } rvec_t;
    rvec_t tbl[12];

    always #5 clk = ~clk;

    ysyx_24100006_csr_unit dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata),
        .wen(wen), .wop(wop), .waddr(waddr), .wdata(wdata),
        .trap_valid(trap_valid), .trap_intr(trap_intr), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .mret_valid(mret_valid), .retire(retire),
        .ext_irq(ext_irq), .irq_take(irq_take), .redirect_pc(redirect_pc),
        .mtvec(mtvec), .mepc(mepc)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected value is queued when the read address is driven, compared once rdata settles.
    task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] e;
        raddr = a;
        sb.push_back(exp);
        #1;
        e = sb.pop_front();
        chk(nm, rdata, e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        waddr = a; wop = op; wdata = d; wen = 1'b1;
        cyc();
        wen = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{"rst_mstatus",   12'h300, 32'h0000_1800};
        tbl[1]  = '{"rst_mvendorid", 12'hF11, 32'h7973_7978};
        tbl[2]  = '{"rst_marchid",   12'hF12, 32'd24100006};
        tbl[3]  = '{"rst_mtvec",     12'h305, 32'h0};
        tbl[4]  = '{"rst_mie",       12'h304, 32'h0};
        tbl[5]  = '{"rst_mscratch",  12'h340, 32'h0};
        tbl[6]  = '{"rst_mepc",      12'h341, 32'h0};
        tbl[7]  = '{"rst_mcause",    12'h342, 32'h0};
        tbl[8]  = '{"rst_mip",       12'h344, 32'h0};
        tbl[9]  = '{"rst_minstret",  12'hB02, 32'h0};
        tbl[10] = '{"rst_minstreth", 12'hB82, 32'h0};
        tbl[11] = '{"rst_unimpl",    12'h301, 32'h0};

        rst_n = 1'b0; raddr = '0; waddr = '0; wdata = '0; wop = 2'b00; wen = 1'b0;
        trap_valid = 1'b0; trap_intr = 1'b0; trap_cause = '0; trap_pc = '0;
        mret_valid = 1'b0; retire = 1'b0; ext_irq = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 12; i++) begin
            rd(tbl[i].nm, tbl[i].addr, tbl[i].exp);
            cyc();
        end
        chk("rst_irq_take", {31'b0, irq_take}, 32'h0);

        wr(12'h301, 2'b00, 32'hFFFF_FFFF);
        rd("unimpl_write", 12'h301, 32'h0);

        raddr = 12'h340;
        waddr = 12'h340; wop = 2'b00; wdata = 32'h0000_A5A5; wen = 1'b1;
        #1 chk("rdw_old", rdata, 32'h0);
        cyc(); wen = 1'b0;
        rd("rdw_new", 12'h340, 32'h0000_A5A5);

        wr(12'h305, 2'b00, 32'h8000_0100);
        wr(12'h304, 2'b01, 32'h0000_0800);
        wr(12'h300, 2'b01, 32'h0000_0008);
        ext_irq = 1'b1;
        #1 chk("irq_take_on", {31'b0, irq_take}, 32'h1);
        rd("mip_ext", 12'h344, 32'h0000_0800);

        trap_valid = 1'b1; trap_intr = 1'b1; trap_cause = 5'd11; trap_pc = 32'h8000_0042;
        #1 chk("trap_redirect", redirect_pc, 32'h8000_0100);
        cyc(); trap_valid = 1'b0;
        chk("trap_mepc", mepc, 32'h8000_0040);
        rd("trap_mcause", 12'h342, 32'h8000_000B);
        rd("trap_mstatus", 12'h300, 32'h0000_1880);
        chk("trap_irq_off", {31'b0, irq_take}, 32'h0);

        mret_valid = 1'b1;
        #1 chk("mret_redirect", redirect_pc, 32'h8000_0040);
        cyc(); mret_valid = 1'b0;
        rd("mret_mstatus", 12'h300, 32'h0000_1888);
        chk("mret_irq_on", {31'b0, irq_take}, 32'h1);

        wr(12'h305, 2'b00, 32'h8000_0103);
        chk("mtvec_bit1", mtvec, 32'h8000_0101);
        trap_intr = 1'b1; trap_cause = 5'd11;
        #1 chk("vec_intr", redirect_pc, 32'h8000_012C);
        trap_intr = 1'b0; trap_cause = 5'd2;
        #1 chk("vec_exc", redirect_pc, 32'h8000_0100);

        trap_valid = 1'b1; trap_pc = 32'h8000_0200; mret_valid = 1'b1;
        waddr = 12'h341; wop = 2'b00; wdata = 32'h0000_1234; wen = 1'b1;
        #1 chk("prio_redirect", redirect_pc, 32'h8000_0100);
        cyc();
        trap_valid = 1'b0; mret_valid = 1'b0; wen = 1'b0;
        chk("prio_mepc", mepc, 32'h8000_0200);
        rd("prio_mcause", 12'h342, 32'h0000_0002);
        rd("prio_mstatus", 12'h300, 32'h0000_1880);

        wr(12'h300, 2'b10, 32'h0000_0088);
        rd("clr_mstatus", 12'h300, 32'h0000_1800);
        wr(12'h340, 2'b11, 32'hFFFF_FFFF);
        rd("nop_mscratch", 12'h340, 32'h0000_A5A5);
        wr(12'h340, 2'b01, 32'h0);
        rd("set0_mscratch", 12'h340, 32'h0000_A5A5);

        wr(12'hB00, 2'b00, 32'hFFFF_FFFE);
        wr(12'hB80, 2'b00, 32'h0);
        rd("mcycle_lo_wr", 12'hB00, 32'hFFFF_FFFE);
        rd("mcycle_hi_wr", 12'hB80, 32'h0);
        cyc(); cyc();
        rd("mcycle_carry_lo", 12'hB00, 32'h0);
        rd("mcycle_carry_hi", 12'hB80, 32'h1);
        wr(12'hB00, 2'b00, 32'hFFFF_FFFF);
        wr(12'hB80, 2'b00, 32'hFFFF_FFFF);
        rd("mcycle_max_hi", 12'hB80, 32'hFFFF_FFFF);
        cyc();
        rd("mcycle_wrap_lo", 12'hB00, 32'h0);
        rd("mcycle_wrap_hi", 12'hB80, 32'h0);

        for (int i = 0; i < 9; i++) begin
            retire = (i % 2 == 0);
            cyc();
        end
        retire = 1'b0;
        rd("minstret_5", 12'hB02, 32'd5);
        rd("minstreth_0", 12'hB82, 32'd0);
        retire = 1'b1;
        wr(12'hB02, 2'b00, 32'd100);
        retire = 1'b0;
        rd("minstret_wr_sup", 12'hB02, 32'd100);
        wr(12'hB02, 2'b01, 32'h3);
        rd("minstret_set", 12'hB02, 32'h0000_0067);

        trap_valid = 1'b1; trap_pc = 32'h8000_0300; retire = 1'b1;
        #2 rst_n = 1'b0;
        rd("async_rst_mepc", 12'h341, 32'h0);
        chk("async_rst_mtvec", mtvec, 32'h0);
        cyc();
        trap_valid = 1'b0; retire = 1'b0;
        rd("async_rst_mstatus", 12'h300, 32'h0000_1800);
        rd("async_rst_mcycle", 12'hB00, 32'h0);
        rd("async_rst_minstret", 12'hB02, 32'h0);
        rst_n = 1'b1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
